// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: step/run clock-enable generator upstream of the MIPS core.
// Optional build macro AUTOREPEAT_EN adds hold-to-repeat stepping in HELD.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 75_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  output logic        cpu_en,
  output logic [15:0] step_count,
  output logic        run_active,
  output logic        step_db
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int DBW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DVW =
    (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DVW-1:0] DV_LAST =
    DVW'(RUN_DIV - 1);

  // synchroniser flops
  logic r_run_ff1;
  logic r_run_s;
  logic r_step_ff1;
  logic r_step_s;

  // debounce state
  logic [DBW-1:0] r_db_cnt;
  logic           r_step_db;
  logic           r_step_db_q;
  logic           w_db_rise;

  // control state
  state_t         r_state;
  state_t         w_state_nxt;
  logic [DVW-1:0] r_div;
  logic [DVW-1:0] w_div_nxt;
  logic           r_cpu_en;
  logic           w_fire;
  logic [15:0]    r_count;

`ifdef AUTOREPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                   : REPEAT_PERIOD;
  localparam int HW =
    (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [HW-1:0] RD_LAST =
    HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RP_LAST =
    HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_nxt;
  logic          r_hold_rep;
  logic          w_hold_rep_nxt;
`endif

  // two-flop synchronisers for the raw switch and button
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_ff1  <= 1'b0;
      r_run_s    <= 1'b0;
      r_step_ff1 <= 1'b0;
      r_step_s   <= 1'b0;
    end else begin
      r_run_ff1  <= run;
      r_run_s    <= r_run_ff1;
      r_step_ff1 <= step;
      r_step_s   <= r_step_ff1;
    end
  end

  // debounce: step_db follows step_s only after a stable run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt    <= '0;
      r_step_db   <= 1'b0;
      r_step_db_q <= 1'b0;
    end else begin
      r_step_db_q <= r_step_db;
      if (r_step_s == r_step_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_step_db <= r_step_s;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_db_rise = r_step_db & ~r_step_db_q;

  // next-state, divider and enable request decode
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_div_nxt   = '0;
`ifdef AUTOREPEAT_EN
    w_hold_cnt_nxt = '0;
    w_hold_rep_nxt = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (r_run_s) begin
          w_state_nxt = S_RUN;
        end else if (w_db_rise) begin
          w_fire      = 1'b1;
          w_state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (r_run_s) begin
          w_state_nxt = S_RUN;
        end else if (!r_step_db) begin
          w_state_nxt = S_IDLE;
        end else begin
`ifdef AUTOREPEAT_EN
          w_hold_rep_nxt = r_hold_rep;
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          if (!r_hold_rep && r_hold_cnt == RD_LAST) begin
            w_fire         = 1'b1;
            w_hold_cnt_nxt = '0;
            w_hold_rep_nxt = 1'b1;
          end else if (r_hold_rep &&
                       r_hold_cnt == RP_LAST) begin
            w_fire         = 1'b1;
            w_hold_cnt_nxt = '0;
          end
`else
          w_state_nxt = S_HELD;
`endif
        end
      end
      S_RUN: begin
        if (!r_run_s) begin
          w_state_nxt = r_step_db ? S_HELD : S_IDLE;
        end else if (r_div == DV_LAST) begin
          w_fire    = 1'b1;
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state, divider, registered enable and enable counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_cpu_en <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_cpu_en <= w_fire;
      if (w_fire) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  // hold timer, zero whenever the FSM is outside HELD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_hold_rep <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_hold_rep <= w_hold_rep_nxt;
    end
  end
`endif

  assign cpu_en     = r_cpu_en;
  assign step_count = r_count;
  assign run_active = (r_state == S_RUN);
  assign step_db    = r_step_db;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl.
// Define AUTOREPEAT_EN to exercise the hold-to-repeat timing.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, step;
  logic        cpu_en, run_active, step_db;
  logic [15:0] step_count;

  logic        reset1, run1, step1;
  logic        cpu_en1, run_active1, step_db1;
  logic [15:0] step_count1;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4), .RUN_DIV(8),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .cpu_en(cpu_en), .step_count(step_count),
    .run_active(run_active), .step_db(step_db)
  );

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4), .RUN_DIV(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut1 (
    .clk(clk), .reset(reset1), .run(run1), .step(step1),
    .cpu_en(cpu_en1), .step_count(step_count1),
    .run_active(run_active1), .step_db(step_db1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  typedef struct {
    int cyc;
    int cnt;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  task automatic push0(input int c, input int n);
    ev_t e;
    e.cyc = c;
    e.cnt = n;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input int n);
    ev_t e;
    e.cyc = c;
    e.cnt = n;
    q1.push_back(e);
  endtask

  // monitor: every enable from dut must match the queue head
  always @(negedge clk) begin : mon0
    ev_t e;
    if (cpu_en === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut unexpected cpu_en at cycle", cyc, -1);
      end else begin
        e = q0.pop_front();
        chk("dut cpu_en cycle", cyc, e.cyc);
        chk("dut step_count", int'(step_count), e.cnt);
      end
    end
  end

  // monitor for the RUN_DIV=1 instance
  always @(negedge clk) begin : mon1
    ev_t e;
    if (cpu_en1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected cpu_en at cycle", cyc, -1);
      end else begin
        e = q1.pop_front();
        chk("dut1 cpu_en cycle", cyc, e.cyc);
        chk("dut1 step_count", int'(step_count1), e.cnt);
      end
    end
  end

  logic db_seen = 1'b0;
  always @(negedge clk)
    if (step_db === 1'b1) db_seen <= 1'b1;

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    goto(cyc + 3);
    reset = 1'b0;
    goto(cyc + 2);
  endtask

  int n;
  int p;

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    reset1 = 1'b1; run1 = 1'b0; step1 = 1'b0;

    // 1. reset state
    goto(3);
    @(negedge clk);
    chk("reset cpu_en", int'(cpu_en), 0);
    chk("reset step_count", int'(step_count), 0);
    chk("reset run_active", int'(run_active), 0);
    chk("reset step_db", int'(step_db), 0);
    chk("reset dut1 step_count", int'(step_count1), 0);
    reset = 1'b0;
    reset1 = 1'b0;
    goto(cyc + 3);

    // 2. 3-cycle glitches never pass the debouncer
    db_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      goto(cyc + 3);
      step = 1'b0;
      goto(cyc + 3);
    end
    goto(cyc + 8);
    @(negedge clk);
    chk("glitch step_db seen", int'(db_seen), 0);
    chk("glitch step_count", int'(step_count), 0);

    // 3. held press: step_db at T+4, one enable at T+5
    goto(cyc + 1);
    n = cyc;
    step = 1'b1;
    push0(n + 7, 1);
`ifdef AUTOREPEAT_EN
    push0(n + 17, 2);
    push0(n + 22, 3);
`endif
    goto(n + 5);
    @(negedge clk);
    chk("press step_db before T+4", int'(step_db), 0);
    goto(n + 6);
    @(negedge clk);
    chk("press step_db at T+4", int'(step_db), 1);
    goto(n + 20);
    step = 1'b0;
    goto(n + 32);
    @(negedge clk);
`ifdef AUTOREPEAT_EN
    chk("press step_count", int'(step_count), 3);
`else
    chk("press step_count", int'(step_count), 1);
`endif
    chk("press released step_db", int'(step_db), 0);
    do_reset();

    // 4. run mode: pulses every 8 cycles after entering RUN
    n = cyc;
    run = 1'b1;
    for (int k = 0; k < 5; k++)
      push0(n + 11 + 8 * k, k + 1);
    goto(n + 2);
    @(negedge clk);
    chk("run_active before sync", int'(run_active), 0);
    goto(n + 20);
    @(negedge clk);
    chk("run_active in RUN", int'(run_active), 1);
    goto(n + 42);
    run = 1'b0;
    goto(n + 64);
    @(negedge clk);
    chk("run_active after exit", int'(run_active), 0);
    chk("run step_count", int'(step_count), 5);
    do_reset();

    // 6. hold past first pulse, then release
    n = cyc;
    step = 1'b1;
    p = n + 7;
    push0(p, 1);
`ifdef AUTOREPEAT_EN
    push0(p + 10, 2);
    push0(p + 15, 3);
    push0(p + 20, 4);
    push0(p + 25, 5);
    push0(p + 30, 6);
`endif
    goto(n + 33);
    step = 1'b0;
    goto(n + 60);
    @(negedge clk);
`ifdef AUTOREPEAT_EN
    chk("hold step_count", int'(step_count), 6);
`else
    chk("hold step_count", int'(step_count), 1);
`endif
    chk("hold released step_db", int'(step_db), 0);
    chk("hold run_active", int'(run_active), 0);

    // 5. RUN_DIV=1: enable every cycle, counter wraps
    goto(cyc + 1);
    n = cyc;
    run1 = 1'b1;
    for (int k = 1; k <= 65540; k++)
      push1(n + 3 + k, k % 65536);
    goto(n + 3 + 65540);
    reset1 = 1'b1;
    run1 = 1'b0;
    goto(cyc + 1);
    @(negedge clk);
    chk("dut1 reset cpu_en", int'(cpu_en1), 0);
    chk("dut1 reset step_count", int'(step_count1), 0);
    goto(cyc + 2);
    reset1 = 1'b0;
    goto(cyc + 10);
    @(negedge clk);
    chk("dut1 after reset step_count",
        int'(step_count1), 0);

    chk("dut pending enables", q0.size(), 0);
    chk("dut1 pending enables", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
